// File: rtl/multdiv_ctrl.sv
// Purpose : iterative signed 32-bit multiply (radix-2 Booth) / divide (restoring) sequencer
//           that time-shares one external carry-lookahead adder through the add_* ports.
// Latency : start edge -> 32 iteration cycles -> result_rdy in cycle 33 (divide-by-zero: cycle 1).
// Backpressure: none; a new start pulse in any state aborts the operation in flight.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   ctrl_mult, ctrl_div          one-cycle start pulses (multiply wins if both are high)
//   operandA, operandB           multiplicand/dividend, multiplier/divisor (sampled on start edge)
//   add_a, add_b, add_cin        drive the shared adder (zero outside MULT/DIV)
//   add_sum, add_overflow        shared adder sum and signed overflow (c31 ^ c32)
//   result, exception            product low word / signed quotient, error flag (held)
//   result_rdy                   one-cycle completion strobe
module multdiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_overflow,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             result_rdy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  // r_m holds M (multiply) or |D| (divide); r_hi/r_lo hold P={hi,lo} or {R,Q}.
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_q;
  logic             r_neg;
  logic             r_dovf;
  logic [WIDTH-1:0] r_result;
  logic             r_exc;

  logic             w_last;
  logic             w_cout;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_div0;
  logic             w_dovf;
  logic [WIDTH-1:0] w_m_hi;
  logic [WIDTH-1:0] w_m_lo;
  logic             w_m_exc;
  logic [WIDTH-1:0] w_r_sh;
  logic             w_r_out;
  logic             w_take;
  logic [WIDTH-1:0] w_d_r;
  logic [WIDTH-1:0] w_d_q;
  logic [WIDTH-1:0] w_quot;

  assign w_last  = (r_cnt == CW'(WIDTH-1));
  // Carry-out recovered from the overflow flag: c32 = ovf ^ c31, c31 = s31 ^ a31 ^ b31.
  assign w_cout  = add_overflow ^ add_sum[WIDTH-1] ^ add_a[WIDTH-1] ^ add_b[WIDTH-1];

  // Local magnitude logic; the most negative value maps onto itself, read as unsigned.
  assign w_abs_a = operandA[WIDTH-1] ? (~operandA + ONE) : operandA;
  assign w_abs_b = operandB[WIDTH-1] ? (~operandB + ONE) : operandB;
  assign w_div0  = (operandB == '0);
  assign w_dovf  = (operandA == MIN_NEG) && (operandB == '1);

  // Booth step: arithmetic shift right of {sum, lo, q}.
  assign w_m_hi  = {add_sum[WIDTH-1], add_sum[WIDTH-1:1]};
  assign w_m_lo  = {add_sum[0], r_lo[WIDTH-1:1]};
  assign w_m_exc = (w_m_hi != {WIDTH{w_m_lo[WIDTH-1]}});

  // Restoring step: trial subtract from the left-shifted remainder. A bit shifted out
  // of R means R_shifted >= 2^32 > D, so the subtraction always succeeds then.
  assign w_r_sh  = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_r_out = r_hi[WIDTH-1];
  assign w_take  = w_cout | w_r_out;
  assign w_d_r   = w_take ? add_sum : w_r_sh;
  assign w_d_q   = {r_lo[WIDTH-2:0], w_take};
  assign w_quot  = r_neg ? (~w_d_q + ONE) : w_d_q;

  assign result     = r_result;
  assign exception  = r_exc;
  assign result_rdy = (r_state == S_DONE);

  // Shared adder operands, purely from state registers.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (r_state)
      S_MULT: begin
        add_a = r_hi;
        case ({r_lo[0], r_q})
          2'b01: add_b = r_m;
          2'b10: begin
            add_b   = ~r_m;
            add_cin = 1'b1;
          end
          default: add_b = '0;
        endcase
      end
      S_DIV: begin
        add_a   = w_r_sh;
        add_b   = ~r_m;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_IDLE;
      S_MULT:  if (w_last) w_state_nxt = S_DONE;
      S_DIV:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // A start pulse overrides whatever is in flight.
    if (ctrl_mult)     w_state_nxt = S_MULT;
    else if (ctrl_div) w_state_nxt = w_div0 ? S_DONE : S_DIV;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_m      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_q      <= 1'b0;
      r_neg    <= 1'b0;
      r_dovf   <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (ctrl_mult) begin
        r_m   <= operandA;
        r_hi  <= '0;
        r_lo  <= operandB;
        r_q   <= 1'b0;
        r_cnt <= '0;
      end else if (ctrl_div) begin
        if (w_div0) begin
          r_result <= '0;
          r_exc    <= 1'b1;
        end else begin
          r_m    <= w_abs_b;
          r_hi   <= '0;
          r_lo   <= w_abs_a;
          r_cnt  <= '0;
          r_neg  <= operandA[WIDTH-1] ^ operandB[WIDTH-1];
          r_dovf <= w_dovf;
        end
      end else begin
        case (r_state)
          S_MULT: begin
            r_hi  <= w_m_hi;
            r_lo  <= w_m_lo;
            r_q   <= r_lo[0];
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_result <= w_m_lo;
              r_exc    <= w_m_exc;
            end
          end
          S_DIV: begin
            r_hi  <= w_d_r;
            r_lo  <= w_d_q;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_result <= w_quot;
              r_exc    <= r_dovf;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Purpose : directed self-checking bench for multdiv_ctrl with a behavioural shared adder.
// Latency : checks completion cycle (33, or 1 for divide-by-zero) and one-cycle strobe width.
// Backpressure: n/a; exercises abort-by-restart, restart during DONE and mid-operation reset.
module tb_multdiv_ctrl;

  logic        clock;
  logic        reset;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_overflow;
  logic [31:0] result;
  logic        exception;
  logic        result_rdy;

  multdiv_ctrl #(.WIDTH(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .ctrl_mult    (ctrl_mult),
    .ctrl_div     (ctrl_div),
    .operandA     (operandA),
    .operandB     (operandB),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_cin      (add_cin),
    .add_sum      (add_sum),
    .add_overflow (add_overflow),
    .result       (result),
    .exception    (exception),
    .result_rdy   (result_rdy)
  );

  // Behavioural stand-in for the external carry-lookahead adder.
  logic [32:0] w_full;
  logic [31:0] w_low31;
  assign w_full       = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};
  assign w_low31      = {1'b0, add_a[30:0]} + {1'b0, add_b[30:0]} + {31'b0, add_cin};
  assign add_sum      = w_full[31:0];
  assign add_overflow = w_low31[31] ^ w_full[32];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_cmp;
  int          n_bad;
  logic [31:0] c1_a;
  logic [31:0] c1_b;
  logic        c1_cin;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a start pulse from posedge+1; returns at posedge+1 of cycle 1.
  task automatic launch(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    ctrl_mult = m;
    ctrl_div  = d;
    operandA  = a;
    operandB  = b;
    @(posedge clock);
    #1;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
  endtask

  // Returns the cycle number (1 = first cycle after the start edge) of the first strobe,
  // or 0 if none within the budget; leaves time at that cycle's negedge.
  task automatic wait_rdy(output int lat, input int budget);
    lat = 0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clock);
      if (n == 1) begin
        c1_a   = add_a;
        c1_b   = add_b;
        c1_cin = add_cin;
      end
      if (result_rdy) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ee, input int el);
    int lat;
    launch(m, d, a, b);
    wait_rdy(lat, 60);
    chk({tag, ".lat"}, 32'(lat), 32'(el));
    chk({tag, ".res"}, result, er);
    chk({tag, ".exc"}, {31'b0, exception}, {31'b0, ee});
    @(posedge clock);
    #1;
    @(negedge clock);
    chk({tag, ".rdy_1cyc"}, {31'b0, result_rdy}, 32'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic seen;
    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    operandA  = '0;
    operandB  = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst.result", result, 32'h0);
    chk("rst.exc",    {31'b0, exception}, 32'd0);
    chk("rst.rdy",    {31'b0, result_rdy}, 32'd0);
    chk("rst.add_a",  add_a, 32'h0);
    chk("rst.add_b",  add_b, 32'h0);
    chk("rst.cin",    {31'b0, add_cin}, 32'd0);
    @(posedge clock);
    #1;

    // Multiply
    run_op("mul7x6",    1'b1, 1'b0, 32'd7, 32'd6, 32'd42, 1'b0, 33);
    run_op("mul-3x5",   1'b1, 1'b0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 1'b0, 33);
    // First Booth step sees {lo[0],q}=10: subtract M=-3, i.e. add 2 with cin=1.
    chk("mul-3x5.c1_a",   c1_a, 32'h0);
    chk("mul-3x5.c1_b",   c1_b, 32'h00000002);
    chk("mul-3x5.c1_cin", {31'b0, c1_cin}, 32'd1);
    run_op("mul2^16sq", 1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h0, 1'b1, 33);
    run_op("mulmaxx2",  1'b1, 1'b0, 32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b1, 33);

    // Divide
    run_op("div-7/2",   1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 33);
    run_op("div7/-2",   1'b0, 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33);
    run_op("div100/7",  1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 1'b0, 33);
    chk("div100/7.c1_a",   c1_a, 32'h0);
    chk("div100/7.c1_b",   c1_b, 32'hFFFFFFF8);
    chk("div100/7.c1_cin", {31'b0, c1_cin}, 32'd1);
    run_op("divmin/1",  1'b0, 1'b1, 32'h80000000, 32'd1, 32'h80000000, 1'b0, 33);
    run_op("divmin/-1", 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 33);

    // Divide by zero: previous result held until the cycle-1 strobe.
    ctrl_div = 1'b1;
    operandA = 32'd55;
    operandB = 32'd0;
    @(negedge clock);
    chk("div0.held", result, 32'h80000000);
    @(posedge clock);
    #1;
    ctrl_div = 1'b0;
    wait_rdy(lat, 60);
    chk("div0.lat", 32'(lat), 32'd1);
    chk("div0.res", result, 32'h0);
    chk("div0.exc", {31'b0, exception}, 32'd1);
    chk("div0.add_a", add_a, 32'h0);
    @(posedge clock);
    #1;

    // Abort: multiply started, divide 10/3 started in cycle 10 -> strobe in cycle 43.
    launch(1'b1, 1'b0, 32'd7, 32'd6);
    seen = 1'b0;
    repeat (9) begin
      @(negedge clock);
      seen = seen | result_rdy;
      @(posedge clock);
      #1;
    end
    launch(1'b0, 1'b1, 32'd10, 32'd3);
    wait_rdy(lat, 60);
    chk("abort.no_early", {31'b0, seen}, 32'd0);
    chk("abort.lat",      32'(lat + 10), 32'd43);
    chk("abort.res",      result, 32'd3);
    chk("abort.exc",      {31'b0, exception}, 32'd0);
    @(posedge clock);
    #1;

    // Both start lines high: multiply (42), not divide (1).
    run_op("both", 1'b1, 1'b1, 32'd7, 32'd6, 32'd42, 1'b0, 33);

    // Reset in cycle 15 of a multiply.
    launch(1'b1, 1'b0, 32'd7, 32'd6);
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("midrst.result", result, 32'h0);
    chk("midrst.exc",    {31'b0, exception}, 32'd0);
    chk("midrst.rdy",    {31'b0, result_rdy}, 32'd0);
    chk("midrst.add_a",  add_a, 32'h0);
    chk("midrst.add_b",  add_b, 32'h0);
    chk("midrst.cin",    {31'b0, add_cin}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      seen = seen | result_rdy;
    end
    chk("midrst.no_rdy", {31'b0, seen}, 32'd0);
    @(posedge clock);
    #1;
    run_op("mul2x3", 1'b1, 1'b0, 32'd2, 32'd3, 32'd6, 1'b0, 33);

    // Start accepted while in DONE: 5*5 completes, -1*-1 launched in its strobe cycle.
    launch(1'b1, 1'b0, 32'd5, 32'd5);
    wait_rdy(lat, 60);
    chk("mul5x5.lat", 32'(lat), 32'd33);
    chk("mul5x5.res", result, 32'd25);
    ctrl_mult = 1'b1;
    operandA  = 32'hFFFFFFFF;
    operandB  = 32'hFFFFFFFF;
    @(posedge clock);
    #1;
    ctrl_mult = 1'b0;
    wait_rdy(lat, 60);
    chk("restart.lat", 32'(lat), 32'd33);
    chk("restart.res", result, 32'd1);
    chk("restart.exc", {31'b0, exception}, 32'd0);
    @(posedge clock);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
Iterative signed 32-bit multiply/divide sequencer for the multdiv unit. It owns a single external 32-bit carry-lookahead adder instance, which it drives through the add_* ports. Multiply is radix-2 Booth and divide is restoring, each taking 32 iteration cycles. It raises a one-cycle result_rdy strobe and holds result/exception until the next completion.

Parameters:
WIDTH, 32, operand and result width (only 32 is supported; iteration count = WIDTH)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
ctrl_mult  in  1  one-cycle start pulse for multiply
ctrl_div  in  1  one-cycle start pulse for divide
operandA  in  32  multiplicand / dividend, sampled on the start edge
operandB  in  32  multiplier / divisor, sampled on the start edge
add_a  out  32  shared adder operand A
add_b  out  32  shared adder operand B
add_cin  out  1  shared adder carry-in
add_sum  in  32  shared adder sum
add_overflow  in  1  shared adder signed overflow (c31 xor c32)
result  out  32  product low word or signed quotient
exception  out  1  multiply overflow, divide-by-zero, or divide overflow
result_rdy  out  1  completion strobe, one cycle wide

Behaviour:
- Reset (clock edge with reset=1): state=IDLE, counter=0, result=0, exception=0, result_rdy=0, add_a=add_b=0, add_cin=0. Reset overrides any start pulse or operation in flight; no result_rdy is issued for an aborted operation.
- States: IDLE, MULT, DIV, DONE.
- Start: ctrl_mult or ctrl_div sampled high in any state starts a new operation and aborts any operation in flight.
  - If both are high, multiply wins.
  - Start in cycle 0 → iteration cycles 1..32 → result_rdy=1 in cycle 33 (latency 33).
- Adder carry-out is derived internally as cout = add_overflow ^ add_sum[31] ^ add_a[31] ^ add_b[31].
- MULT:
  - Registers: M (multiplicand), 64-bit P={hi,lo} with lo=multiplier and hi=0, plus Booth bit q=0.
  - Each iteration drives add_a=hi. Select on {lo[0],q}:
    - 01: add_b=M, cin=0.
    - 10: add_b=~M, cin=1.
    - 00/11: add_b=0, cin=0.
  - Then arithmetic-shift-right {add_sum,lo,q} by 1.
  - After 32 iterations: result=lo; exception=1 iff hi is not all copies of lo[31].
- DIV:
  - Operand magnitudes come from local negation logic (~x+1), not the shared adder. |-2^31| = 0x80000000 is treated as unsigned.
  - Quotient sign = A[31]^B[31].
  - Registers: R=0, Q=|A|, D=|B|.
  - Each iteration: shift {R,Q} left by 1, then add_a=R_shifted, add_b=~D, cin=1.
    - If cout=1 or the bit shifted out of R is 1: R=add_sum, Q[0]=1.
    - Otherwise R is unchanged and Q[0]=0.
  - After 32 iterations: result = sign ? -Q : Q.
  - Rounding truncates toward zero. Remainder is discarded.
- Divide-by-zero (B=0 at the start edge): no iterations; go directly to DONE. result=0, exception=1, result_rdy=1 in cycle 1.
- Divide overflow (-2^31 / -1): exception=1, result=0x80000000.
- DONE:
  - result_rdy=1 for exactly one cycle, then IDLE.
  - A start pulse during DONE is accepted: result_rdy stays 1 that cycle and the new operation begins.
- result and exception update only on completion and hold until the next completion. exception is valid whenever result_rdy=1.
- In IDLE/DONE, add_a=add_b=0 and add_cin=0. add_* are combinational from the state registers and are valid every MULT/DIV cycle.

Test Plan:
- Reset, then ctrl_mult with A=7, B=6 → result_rdy=1 in cycle 33 only, result=42, exception=0; ctrl_mult with A=-3, B=5 → result=0xFFFFFFF1, exception=0.
- ctrl_mult with A=0x00010000, B=0x00010000 → result=0x00000000, exception=1; A=0x7FFFFFFF, B=2 → result=0xFFFFFFFE, exception=1.
- ctrl_div: -7/2 → 0xFFFFFFFD; 7/-2 → 0xFFFFFFFD; 100/7 → 14; 0x80000000/1 → 0x80000000; 0x80000000/-1 → 0x80000000 with exception=1; all except the last have exception=0 and complete in cycle 33.
- ctrl_div with B=0 → result_rdy in cycle 1, result=0, exception=1; prior result value held until then.
- Start mult 7*6, then assert ctrl_div 10/3 in cycle 10 → no strobe for the multiply; result_rdy in cycle 43 with result=3. Both ctrl lines high together → a multiply is performed.
- reset asserted in cycle 15 of a multiply → next cycle all outputs are 0 and state is IDLE; no result_rdy occurs; a subsequent 2*3 gives 6 at latency 33.
